// File: rtl/subreg_pkg.sv
// Shared definitions for the sub-regulated divider / rate meter family:
// gate FSM state encoding and default period width.
package subreg_pkg;

  localparam int unsigned C_PERIOD_W_DEF = 31;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

endpackage

// File: rtl/subreg_gap_tracker.sv
// Pulse-spacing tracker: measures clocks between EN_i highs and keeps per-gate
// min/max. Instantiated by subreg_rate_meter under SUBREG_RATE_METER_GAP_CHK_EN.
module subreg_gap_tracker
  import subreg_pkg::*;
#(
  parameter int unsigned C_PERIOD_W = C_PERIOD_W_DEF
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic                  EN_i,
  input  logic                  gate_start_i,
  input  logic                  gate_end_i,
  input  logic                  active_i,
  output logic [C_PERIOD_W-1:0] GAP_MIN_o,
  output logic [C_PERIOD_W-1:0] GAP_MAX_o
);

  localparam logic [C_PERIOD_W-1:0] ONES = '1;
  localparam logic [C_PERIOD_W-1:0] ONE  = C_PERIOD_W'(1);

  logic                  armed_q,   armed_d;
  logic [C_PERIOD_W-1:0] dist_q,    dist_d;
  logic [C_PERIOD_W-1:0] min_q,     min_d;
  logic [C_PERIOD_W-1:0] max_q,     max_d;
  logic [C_PERIOD_W-1:0] gap_min_q, gap_min_d;
  logic [C_PERIOD_W-1:0] gap_max_q, gap_max_d;
  logic [C_PERIOD_W-1:0] min_nxt,   max_nxt;

  always_comb begin
    armed_d   = armed_q;
    dist_d    = dist_q;
    min_d     = min_q;
    max_d     = max_q;
    gap_min_d = gap_min_q;
    gap_max_d = gap_max_q;
    // Accumulators restart on the first gate cycle, so a gap closing there counts.
    min_nxt   = gate_start_i ? ONES : min_q;
    max_nxt   = gate_start_i ? '0   : max_q;
    if (!active_i) begin
      armed_d = 1'b0;
      dist_d  = '0;
      min_d   = '0;
      max_d   = '0;
    end else begin
      if (EN_i) begin
        if (armed_q) begin
          if (dist_q < min_nxt) min_nxt = dist_q;
          if (dist_q > max_nxt) max_nxt = dist_q;
        end
        armed_d = 1'b1;
        dist_d  = ONE;
      end else if (armed_q && (dist_q != ONES)) begin
        dist_d = dist_q + ONE;
      end
      min_d = min_nxt;
      max_d = max_nxt;
      if (gate_end_i) begin
        gap_min_d = min_nxt;
        gap_max_d = max_nxt;
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      armed_q   <= 1'b0;
      dist_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      gap_min_q <= '0;
      gap_max_q <= '0;
    end else begin
      armed_q   <= armed_d;
      dist_q    <= dist_d;
      min_q     <= min_d;
      max_q     <= max_d;
      gap_min_q <= gap_min_d;
      gap_max_q <= gap_max_d;
    end
  end

  assign GAP_MIN_o = gap_min_q;
  assign GAP_MAX_o = gap_max_q;

endmodule

// File: rtl/subreg_rate_meter.sv
// Counts EN_i highs over back-to-back gates of PERIOD_i clocks.
// Gap statistics are built only when SUBREG_RATE_METER_GAP_CHK_EN is defined.
module subreg_rate_meter
  import subreg_pkg::*;
#(
  parameter int unsigned C_PERIOD_W = C_PERIOD_W_DEF
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic                  RUN_i,
  input  logic [C_PERIOD_W-1:0] PERIOD_i,
  input  logic                  EN_i,
  output logic [C_PERIOD_W-1:0] PULSE_N_o,
  output logic                  DONE_o,
  output logic [C_PERIOD_W-1:0] GAP_MIN_o,
  output logic [C_PERIOD_W-1:0] GAP_MAX_o
);

  localparam logic [C_PERIOD_W-1:0] ONE = C_PERIOD_W'(1);

  state_t                state_q,   state_d;
  logic [C_PERIOD_W-1:0] per_q,     per_d;
  logic [C_PERIOD_W-1:0] gcnt_q,    gcnt_d;
  logic [C_PERIOD_W-1:0] pcnt_q,    pcnt_d;
  logic [C_PERIOD_W-1:0] pulse_n_q, pulse_n_d;
  logic                  done_q,    done_d;

  logic                  idle;
  logic                  active;
  logic                  last;
  logic [C_PERIOD_W-1:0] cur_per;
  logic [C_PERIOD_W-1:0] gcnt_cur;
  logic [C_PERIOD_W-1:0] cnt;

  // The IDLE cycle that sees RUN_i high is already gate cycle 0, using PERIOD_i
  // directly, so the first strobe lands exactly per cycles after RUN_i rises.
  always_comb begin
    idle     = (state_q == IDLE);
    cur_per  = idle ? PERIOD_i : per_q;
    gcnt_cur = idle ? '0 : gcnt_q;
    cnt      = (idle ? '0 : pcnt_q) + C_PERIOD_W'(EN_i);
    active   = RUN_i && (!idle || (PERIOD_i != '0));
    last     = active && (gcnt_cur == (cur_per - ONE));
  end

  always_comb begin
    state_d   = IDLE;
    per_d     = per_q;
    gcnt_d    = '0;
    pcnt_d    = '0;
    pulse_n_d = pulse_n_q;
    done_d    = 1'b0;
    if (active) begin
      if (last) begin
        pulse_n_d = cnt;
        done_d    = 1'b1;
        per_d     = PERIOD_i;
        state_d   = (PERIOD_i != '0) ? GATE : IDLE;
      end else begin
        per_d     = cur_per;
        gcnt_d    = gcnt_cur + ONE;
        pcnt_d    = cnt;
        state_d   = GATE;
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q   <= IDLE;
      per_q     <= '0;
      gcnt_q    <= '0;
      pcnt_q    <= '0;
      pulse_n_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      gcnt_q    <= gcnt_d;
      pcnt_q    <= pcnt_d;
      pulse_n_q <= pulse_n_d;
      done_q    <= done_d;
    end
  end

  assign PULSE_N_o = pulse_n_q;
  assign DONE_o    = done_q;

`ifdef SUBREG_RATE_METER_GAP_CHK_EN
  logic gate_start;
  assign gate_start = active && (gcnt_cur == '0);

  subreg_gap_tracker #(
    .C_PERIOD_W (C_PERIOD_W)
  ) u_gap (
    .CK_i         (CK_i),
    .XARST_i      (XARST_i),
    .EN_i         (EN_i),
    .gate_start_i (gate_start),
    .gate_end_i   (last),
    .active_i     (active),
    .GAP_MIN_o    (GAP_MIN_o),
    .GAP_MAX_o    (GAP_MAX_o)
  );
`else
  assign GAP_MIN_o = '0;
  assign GAP_MAX_o = '0;
`endif

endmodule

// File: tb/tb_subreg_rate_meter.sv
// Directed self-checking bench for subreg_rate_meter; gap expectations follow
// SUBREG_RATE_METER_GAP_CHK_EN (tied to 0 when undefined).
module tb_subreg_rate_meter;

  localparam int unsigned W = 31;
`ifdef SUBREG_RATE_METER_GAP_CHK_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam logic [W-1:0] ONES = '1;

  logic         CK_i;
  logic         XARST_i;
  logic         RUN_i;
  logic [W-1:0] PERIOD_i;
  logic         EN_i;
  logic [W-1:0] PULSE_N_o;
  logic         DONE_o;
  logic [W-1:0] GAP_MIN_o;
  logic [W-1:0] GAP_MAX_o;

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  int phase  = 0;

  subreg_rate_meter #(
    .C_PERIOD_W (W)
  ) dut (
    .CK_i      (CK_i),
    .XARST_i   (XARST_i),
    .RUN_i     (RUN_i),
    .PERIOD_i  (PERIOD_i),
    .EN_i      (EN_i),
    .PULSE_N_o (PULSE_N_o),
    .DONE_o    (DONE_o),
    .GAP_MIN_o (GAP_MIN_o),
    .GAP_MAX_o (GAP_MAX_o)
  );

  initial CK_i = 1'b0;
  always #5 CK_i = ~CK_i;

  // 0: constant low, 1: constant high, 2: divider 3-of-7, 3: burst HHHLLLL
  function automatic logic pat(input int m, input int ph);
    case (m)
      1:       return 1'b1;
      2:       return (((ph + 1) * 3) / 7) != ((ph * 3) / 7);
      3:       return (ph % 7) < 3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge CK_i);
    #1;
    phase++;
    EN_i = pat(mode, phase);
  endtask

  task automatic start(input int m, input int per);
    mode     = m;
    phase    = 0;
    EN_i     = pat(m, 0);
    PERIOD_i = W'(per);
    RUN_i    = 1'b1;
  endtask

  task automatic stop();
    RUN_i = 1'b0;
    step();
    step();
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!DONE_o && n < max);
  endtask

  task automatic test_reset();
    XARST_i = 1'b0; RUN_i = 1'b0; PERIOD_i = '0; EN_i = 1'b0;
    #12;
    checks++; if (PULSE_N_o !== '0) begin errors++; $display("FAIL reset_pulse_n got=%0d exp=0", PULSE_N_o); end
    checks++; if (DONE_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", DONE_o); end
    checks++; if (GAP_MIN_o !== '0) begin errors++; $display("FAIL reset_gap_min got=%0d exp=0", GAP_MIN_o); end
    checks++; if (GAP_MAX_o !== '0) begin errors++; $display("FAIL reset_gap_max got=%0d exp=0", GAP_MAX_o); end
    @(posedge CK_i); #1;
    XARST_i = 1'b1;
    step();
  endtask

  task automatic test_divider();
    int n;
    start(2, 7);
    wait_done(20, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL div_first_latency got=%0d exp=7", n); end
    checks++; if (PULSE_N_o !== 3) begin errors++; $display("FAIL div_count1 got=%0d exp=3", PULSE_N_o); end
    checks++; if (GAP_MAX_o !== (GAP ? 2 : 0)) begin errors++; $display("FAIL div_gap_max1 got=%0d exp=%0d", GAP_MAX_o, GAP ? 2 : 0); end
    wait_done(20, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL div_period got=%0d exp=7", n); end
    checks++; if (PULSE_N_o !== 3) begin errors++; $display("FAIL div_count2 got=%0d exp=3", PULSE_N_o); end
    checks++; if (GAP_MIN_o !== (GAP ? 2 : 0)) begin errors++; $display("FAIL div_gap_min got=%0d exp=%0d", GAP_MIN_o, GAP ? 2 : 0); end
    checks++; if (GAP_MAX_o !== (GAP ? 3 : 0)) begin errors++; $display("FAIL div_gap_max got=%0d exp=%0d", GAP_MAX_o, GAP ? 3 : 0); end
    step();
    checks++; if (DONE_o !== 1'b0) begin errors++; $display("FAIL div_strobe_width got=%0b exp=0", DONE_o); end
    stop();
  endtask

  task automatic test_const_high();
    int n;
    start(1, 5);
    wait_done(20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL c1_latency got=%0d exp=5", n); end
    checks++; if (PULSE_N_o !== 5) begin errors++; $display("FAIL c1_count got=%0d exp=5", PULSE_N_o); end
    checks++; if (GAP_MIN_o !== (GAP ? 1 : 0)) begin errors++; $display("FAIL c1_gap_min got=%0d exp=%0d", GAP_MIN_o, GAP ? 1 : 0); end
    checks++; if (GAP_MAX_o !== (GAP ? 1 : 0)) begin errors++; $display("FAIL c1_gap_max got=%0d exp=%0d", GAP_MAX_o, GAP ? 1 : 0); end
    stop();
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    start(1, 10);
    step(); step(); step();
    RUN_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (DONE_o) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%0b exp=0", seen); end
    checks++; if (PULSE_N_o !== 5) begin errors++; $display("FAIL abort_held got=%0d exp=5", PULSE_N_o); end
    start(1, 10);
    wait_done(30, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL abort_restart_latency got=%0d exp=10", n); end
    checks++; if (PULSE_N_o !== 10) begin errors++; $display("FAIL abort_restart_count got=%0d exp=10", PULSE_N_o); end
    stop();
  endtask

  task automatic test_period_change();
    int n;
    start(1, 4);
    step(); step();
    PERIOD_i = W'(6);
    wait_done(20, n);
    checks++; if (n + 2 !== 4) begin errors++; $display("FAIL perchg_first got=%0d exp=4", n + 2); end
    checks++; if (PULSE_N_o !== 4) begin errors++; $display("FAIL perchg_count1 got=%0d exp=4", PULSE_N_o); end
    wait_done(20, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL perchg_second got=%0d exp=6", n); end
    checks++; if (PULSE_N_o !== 6) begin errors++; $display("FAIL perchg_count2 got=%0d exp=6", PULSE_N_o); end
    stop();
  endtask

  task automatic test_zero_period();
    bit seen;
    start(1, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (DONE_o) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_no_done got=%0b exp=0", seen); end
    checks++; if (PULSE_N_o !== 6) begin errors++; $display("FAIL zero_held got=%0d exp=6", PULSE_N_o); end
    stop();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start(1, 8);
    step(); step(); step(); step();
    XARST_i = 1'b0;
    #1;
    checks++; if (PULSE_N_o !== '0) begin errors++; $display("FAIL rstmid_pulse_n got=%0d exp=0", PULSE_N_o); end
    checks++; if (DONE_o !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%0b exp=0", DONE_o); end
    checks++; if (GAP_MIN_o !== '0) begin errors++; $display("FAIL rstmid_gap_min got=%0d exp=0", GAP_MIN_o); end
    checks++; if (GAP_MAX_o !== '0) begin errors++; $display("FAIL rstmid_gap_max got=%0d exp=0", GAP_MAX_o); end
    RUN_i = 1'b0;
    step();
    XARST_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (DONE_o) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%0b exp=0", seen); end
  endtask

  task automatic test_const_low();
    int n;
    start(0, 5);
    wait_done(20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL c0_latency got=%0d exp=5", n); end
    checks++; if (PULSE_N_o !== 0) begin errors++; $display("FAIL c0_count got=%0d exp=0", PULSE_N_o); end
    checks++; if (GAP_MIN_o !== (GAP ? ONES : '0)) begin errors++; $display("FAIL c0_gap_min got=%0h exp=%0h", GAP_MIN_o, GAP ? ONES : '0); end
    checks++; if (GAP_MAX_o !== '0) begin errors++; $display("FAIL c0_gap_max got=%0d exp=0", GAP_MAX_o); end
    stop();
  endtask

  task automatic test_bunched();
    int n;
    start(3, 7);
    wait_done(20, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL burst_latency got=%0d exp=7", n); end
    checks++; if (GAP_MAX_o !== (GAP ? 1 : 0)) begin errors++; $display("FAIL burst_gap_max1 got=%0d exp=%0d", GAP_MAX_o, GAP ? 1 : 0); end
    wait_done(20, n);
    checks++; if (PULSE_N_o !== 3) begin errors++; $display("FAIL burst_count got=%0d exp=3", PULSE_N_o); end
    checks++; if (GAP_MIN_o !== (GAP ? 1 : 0)) begin errors++; $display("FAIL burst_gap_min got=%0d exp=%0d", GAP_MIN_o, GAP ? 1 : 0); end
    checks++; if (GAP_MAX_o !== (GAP ? 5 : 0)) begin errors++; $display("FAIL burst_gap_max got=%0d exp=%0d", GAP_MAX_o, GAP ? 5 : 0); end
    stop();
  endtask

  initial begin
    test_reset();
    test_divider();
    test_const_high();
    test_abort();
    test_period_change();
    test_zero_period();
    test_reset_mid();
    test_const_low();
    test_bunched();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
